tt_um_serial_sub: RTL and testbench
===================================

TT_UM_SERIAL_SUB -- requirements
Module: tt_um_serial_sub

Interface
REQ-001 clk  input  1  sole clock; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 ena  input  1  design enable; low = all registers hold.
REQ-004 ui_in  input  8  operand data byte.
REQ-005 uio_in  input  8  control: [0] load_a, [1] load_b, [2] start; [7:3] ignored.
REQ-006 uo_out  output  8  difference register D.
REQ-007 uio_out  output  8  [3:0]=0, [4] busy, [5] done, [6] borrow, [7] last serial difference bit.
REQ-008 uio_oe  output  8  constant 8'hF0.

Function
REQ-009 The block SHALL compute D = (A - B) mod 256, LSB-first, one bit per enabled clock, via a full-subtractor cell plus a borrow flip-flop.
REQ-010 The FSM SHALL have states IDLE and RUN; busy = (state == RUN).
REQ-011 In IDLE with ena=1, load_a SHALL capture ui_in into A, and load_b SHALL capture ui_in into B; both may load the same byte in one cycle.
REQ-012 In IDLE, start=1 with load_a=0 and load_b=0 SHALL:
  - enter RUN
  - clear the borrow FF, the bit counter, and done.
REQ-013 In IDLE, start coincident with any load SHALL be ignored; the load still occurs.
REQ-014 Each RUN cycle SHALL compute the following, then shift A and B right by one and update borrow with bout:
  - d = a0 ^ b0 ^ bin
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
  - shift d into D[7], with D shifting right
  - register d to uio_out[7]
REQ-015 The bit counter (3 bits) SHALL advance each RUN cycle. On the 8th RUN cycle (count 7) the FSM SHALL:
  - return to IDLE
  - set done=1
  - leave borrow = final bout (1 iff A < B unsigned).
REQ-016 Latency: with start sampled at edge k, busy is high after edges k..k+7; D, borrow, and done are valid after edge k+8.
REQ-017 done SHALL remain high until the next accepted start; D and borrow hold until then.
REQ-018 load_a, load_b, and start SHALL be ignored while busy.
REQ-019 After a run, A and B hold shifted-out contents (undefined for reuse); the user must reload them before the next start.
REQ-020 ena=0 SHALL freeze all registers, including mid-RUN; the run resumes when ena returns high.

Reset
REQ-021 rst_n low SHALL asynchronously force the following to zero:
  - state=IDLE
  - A, B, D
  - borrow, counter, done
  - serial bit
REQ-022 Reset mid-RUN SHALL abort the operation with no residual state.
REQ-023 uio_oe SHALL read 8'hF0 during and after reset; all other outputs read 0 during reset.

Structure
REQ-024 A shared package SHALL hold:
  - operand width (8)
  - state encoding
  - uio control and status bit indices.
REQ-025 The full-subtractor cell SHALL be a combinational sub-module tt_serial_fs (a, b, bin -> d, bout).
REQ-026 Target size: 120-250 lines of RTL including the sub-module.

Verification
REQ-027 Load A=0x35, B=0x12, start -> after 8 cycles D=0x23, borrow=0, done=1; busy high exactly 8 cycles.
REQ-028 A=0x00, B=0x01 -> D=0xFF, borrow=1. A=0xFF, B=0xFF -> D=0x00, borrow=0.
REQ-029 Serial bit trace for A=0x35, B=0x12 -> uio_out[7] sequence LSB-first 1,1,0,0,0,1,0,0.
REQ-030 A=0x10, B=0x01 running; assert start and load_a=0xAA mid-run -> both ignored; D=0x0F, borrow=0.
REQ-031 rst_n low at RUN cycle 4 -> all outputs 0 immediately, except uio_oe=0xF0; after release, a fresh A=0x80, B=0x7F run gives D=0x01.
REQ-032 start with load_b=1 in the same cycle -> B loaded, busy stays 0; ena=0 for 3 cycles mid-run -> result unchanged, latency extended by 3.

Source files
------------

// File: rtl/tt_um_serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: operand width, FSM encoding,
// and the bit positions of the uio control/status fields.
package tt_um_serial_sub_pkg;

   localparam int WIDTH     = 8;
   localparam int CNT_W     = 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int CTL_LOAD_A = 0;
   localparam int CTL_LOAD_B = 1;
   localparam int CTL_START  = 2;

   localparam int STS_BUSY   = 4;
   localparam int STS_DONE   = 5;
   localparam int STS_BORROW = 6;
   localparam int STS_SERIAL = 7;

   localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/tt_um_serial_sub_fs.sv
// Combinational full-subtractor cell: d = a - b - bin, with borrow out.
module tt_serial_fs (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/tt_um_serial_sub.sv
// Bit-serial 8-bit subtractor: D = (A - B) mod 256, LSB first, one bit per
// enabled clock, with the final borrow flagging A < B.
module tt_um_serial_sub
   import tt_um_serial_sub_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_borrow;
   logic             r_done;
   logic             r_serial;

   logic w_load_a;
   logic w_load_b;
   logic w_start;
   logic w_d;
   logic w_bout;
   logic w_busy;
   logic w_unused_ctl;

   assign w_load_a     = uio_in[CTL_LOAD_A];
   assign w_load_b     = uio_in[CTL_LOAD_B];
   assign w_start      = uio_in[CTL_START];
   assign w_busy       = (r_state == ST_RUN);
   assign w_unused_ctl = &{1'b0, uio_in[7:3]};

   tt_serial_fs u_fs (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   // Operand capture in IDLE, one subtractor step per RUN cycle; ena gates everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_a      <= 8'h00;
         r_b      <= 8'h00;
         r_d      <= 8'h00;
         r_cnt    <= 3'd0;
         r_borrow <= 1'b0;
         r_done   <= 1'b0;
         r_serial <= 1'b0;
      end else if (ena) begin
         case (r_state)
            ST_IDLE: begin
               if (w_load_a) begin
                  r_a <= ui_in;
               end
               if (w_load_b) begin
                  r_b <= ui_in;
               end
               // A start is only honoured when no load competes for the same cycle.
               if (w_start && !w_load_a && !w_load_b) begin
                  r_state  <= ST_RUN;
                  r_borrow <= 1'b0;
                  r_cnt    <= 3'd0;
                  r_done   <= 1'b0;
               end
            end
            ST_RUN: begin
               r_a      <= {1'b0, r_a[WIDTH-1:1]};
               r_b      <= {1'b0, r_b[WIDTH-1:1]};
               r_d      <= {w_d, r_d[WIDTH-1:1]};
               r_serial <= w_d;
               r_borrow <= w_bout;
               r_cnt    <= r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign uo_out  = r_d;
   assign uio_out = {r_serial, r_borrow, r_done, w_busy, 4'b0000};
   assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Directed self-checking bench for the bit-serial subtractor.
module tb_tt_um_serial_sub;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks;
   int errors;

   tt_um_serial_sub dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
      uio_in = 8'h01; ui_in = a; step();
      uio_in = 8'h02; ui_in = b; step();
      uio_in = 8'h00; ui_in = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
      #12;
      checks++;
      if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
      checks++;
      if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
      checks++;
      if (uio_oe !== 8'hF0) begin errors++; $display("FAIL reset_uio_oe got %h want F0", uio_oe); end
      #3 rst_n = 1'b1;
      step();
      checks++;
      if (uio_oe !== 8'hF0) begin errors++; $display("FAIL post_reset_uio_oe got %h want F0", uio_oe); end
   endtask

   task automatic do_run(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_d, input logic exp_bo,
                         input logic chk_trace, input logic [7:0] exp_trace);
      int busy_cnt;
      logic [7:0] trace;
      load_ops(a, b);
      uio_in = 8'h04; step(); uio_in = 8'h00;
      busy_cnt = 0;
      trace = 8'h00;
      if (uio_out[4]) busy_cnt++;
      for (int i = 0; i < 8; i++) begin
         step();
         trace[i] = uio_out[7];
         if (uio_out[4]) busy_cnt++;
      end
      checks++;
      if (uo_out !== exp_d) begin errors++; $display("FAIL %s_d got %h want %h", name, uo_out, exp_d); end
      checks++;
      if (uio_out[6] !== exp_bo) begin errors++; $display("FAIL %s_borrow got %b want %b", name, uio_out[6], exp_bo); end
      checks++;
      if (uio_out[5] !== 1'b1) begin errors++; $display("FAIL %s_done got %b want 1", name, uio_out[5]); end
      checks++;
      if (busy_cnt != 8) begin errors++; $display("FAIL %s_busy_cycles got %0d want 8", name, busy_cnt); end
      if (chk_trace) begin
         checks++;
         if (trace !== exp_trace) begin errors++; $display("FAIL %s_trace got %b want %b", name, trace, exp_trace); end
      end
   endtask

   task automatic test_basic();
      // Serial bits LSB-first 1,1,0,0,0,1,0,0 -> collected as 8'b00100011.
      do_run("basic", 8'h35, 8'h12, 8'h23, 1'b0, 1'b1, 8'b0010_0011);
      step(); step(); step();
      checks++;
      if (uio_out[6:5] !== 2'b01 || uo_out !== 8'h23) begin
         errors++; $display("FAIL hold_after_done got d=%h st=%b want d=23 st=01", uo_out, uio_out[6:5]);
      end
   endtask

   task automatic test_boundaries();
      do_run("underflow", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 8'h00);
      do_run("equal_ff",  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_ignore_mid_run();
      load_ops(8'h10, 8'h01);
      uio_in = 8'h04; step(); uio_in = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin uio_in = 8'h05; ui_in = 8'hAA; end
         else begin uio_in = 8'h00; ui_in = 8'h00; end
         step();
      end
      uio_in = 8'h00; ui_in = 8'h00;
      checks++;
      if (uo_out !== 8'h0F) begin errors++; $display("FAIL ignore_d got %h want 0F", uo_out); end
      checks++;
      if (uio_out[6:4] !== 3'b010) begin errors++; $display("FAIL ignore_status got %b want 010", uio_out[6:4]); end
   endtask

   task automatic test_reset_mid_run();
      load_ops(8'h35, 8'h12);
      uio_in = 8'h04; step(); uio_in = 8'h00;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (uio_out[4] !== 1'b1) begin errors++; $display("FAIL pre_abort_busy got %b want 1", uio_out[4]); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         errors++; $display("FAIL abort_outputs got uo=%h uio=%h want 00 00", uo_out, uio_out);
      end
      checks++;
      if (uio_oe !== 8'hF0) begin errors++; $display("FAIL abort_uio_oe got %h want F0", uio_oe); end
      @(negedge clk); rst_n = 1'b1;
      step();
      do_run("after_abort", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_start_with_load_and_stall();
      uio_in = 8'h01; ui_in = 8'h05; step();
      uio_in = 8'h06; ui_in = 8'h03; step();
      uio_in = 8'h00; ui_in = 8'h00;
      checks++;
      if (uio_out[4] !== 1'b0) begin errors++; $display("FAIL start_with_load_busy got %b want 0", uio_out[4]); end
      uio_in = 8'h04; step(); uio_in = 8'h00;
      for (int i = 0; i < 10; i++) begin
         ena = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
         step();
      end
      ena = 1'b1;
      checks++;
      if (uio_out[5:4] !== 2'b01) begin errors++; $display("FAIL stall_still_busy got %b want 01", uio_out[5:4]); end
      step();
      checks++;
      if (uo_out !== 8'h02) begin errors++; $display("FAIL stall_d got %h want 02", uo_out); end
      checks++;
      if (uio_out[6:4] !== 3'b010) begin errors++; $display("FAIL stall_status got %b want 010", uio_out[6:4]); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_boundaries();
      test_ignore_mid_run();
      test_reset_mid_run();
      test_start_with_load_and_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
